// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters; owns the Z/V/N flag register.
// Optional macro ARB_FIXED_PRIO_EN: port 0 always wins contention instead of round-robin.
module alu_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [2:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_z,
    input  logic             alu_v,
    input  logic             alu_n,
    output logic             flag_z,
    output logic             flag_v,
    output logic             flag_n,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             owner_q, owner_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             flag_z_q, flag_z_d;
    logic             flag_v_q, flag_v_d;
    logic             flag_n_q, flag_n_d;
    logic             gnt_vld;
    logic             gnt_id;

`ifdef ARB_FIXED_PRIO_EN
    always_comb begin
        gnt_vld = req0_valid | req1_valid;
        gnt_id  = ~req0_valid;
    end
`else
    logic last_q, last_d;

    // On contention the port not served last wins; otherwise the lone valid port.
    always_comb begin
        gnt_vld = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            gnt_id = ~last_q;
        end else begin
            gnt_id = req1_valid;
        end
    end
`endif

    assign req0_ready = (state_q == IDLE) & gnt_vld & ~gnt_id;
    assign req1_ready = (state_q == IDLE) & gnt_vld & gnt_id;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        rsp_data_d = rsp_data_q;
        flag_z_d   = flag_z_q;
        flag_v_d   = flag_v_q;
        flag_n_d   = flag_n_q;
`ifndef ARB_FIXED_PRIO_EN
        last_d     = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    owner_d = gnt_id;
                    op_d    = gnt_id ? req1_op : req0_op;
                    a_d     = gnt_id ? req1_a : req0_a;
                    b_d     = gnt_id ? req1_b : req0_b;
`ifndef ARB_FIXED_PRIO_EN
                    last_d  = gnt_id;
`endif
                    state_d = EXEC;
                end
            end
            EXEC: begin
                rsp_data_d = alu_out;
                flag_z_d   = alu_z;
                // Only ADD (000) and SUB (001) produce meaningful V/N.
                if (op_q[2:1] == 2'b00) begin
                    flag_v_d = alu_v;
                    flag_n_d = alu_n;
                end
                state_d = RESP;
            end
            RESP: begin
                if (owner_q ? rsp1_ready : rsp0_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            rsp_data_q <= '0;
            flag_z_q   <= 1'b0;
            flag_v_q   <= 1'b0;
            flag_n_q   <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
            last_q     <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            rsp_data_q <= rsp_data_d;
            flag_z_q   <= flag_z_d;
            flag_v_q   <= flag_v_d;
            flag_n_q   <= flag_n_d;
`ifndef ARB_FIXED_PRIO_EN
            last_q     <= last_d;
`endif
        end
    end

    assign rsp0_valid = (state_q == RESP) & ~owner_q;
    assign rsp1_valid = (state_q == RESP) & owner_q;
    assign rsp_data   = rsp_data_q;
    assign alu_op     = op_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign flag_z     = flag_z_q;
    assign flag_v     = flag_v_q;
    assign flag_n     = flag_n_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Transaction-level bench for alu_arbiter: directed scenarios then randomized traffic, with an ALU stand-in.
module tb_alu_arbiter;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [2:0]   req0_op, req1_op;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [W-1:0] rsp_data;
    logic [2:0]   alu_op;
    logic [W-1:0] alu_a, alu_b, alu_out;
    logic         alu_z, alu_v, alu_n;
    logic         flag_z, flag_v, flag_n, busy;

    alu_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_data(rsp_data), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
        .alu_z(alu_z), .alu_v(alu_v), .alu_n(alu_n),
        .flag_z(flag_z), .flag_v(flag_v), .flag_n(flag_n), .busy(busy)
    );

    always #5 clk = ~clk;

    // ALU stand-in: returns {v, n, result}. Non-arithmetic ops report junk V/N the arbiter must ignore.
    function automatic logic [17:0] alu_calc(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        logic        v, n;
        r = 16'h0;
        v = 1'b0;
        n = 1'b0;
        case (op)
            3'd0: begin r = a + b; v = (a[15] == b[15]) && (r[15] != a[15]); n = r[15]; end
            3'd1: begin r = a - b; v = (a[15] != b[15]) && (r[15] != a[15]); n = r[15]; end
            3'd2: r = a ^ b;
            3'd3: r = {15'h0, ^a};
            3'd4: r = a << b[3:0];
            3'd5: r = a >> b[3:0];
            3'd6: r = $signed(a) >>> b[3:0];
            default: r = {a[15:8] + b[15:8], a[7:0] + b[7:0]};
        endcase
        if (op > 3'd1) begin
            v = 1'b1;
            n = ~r[15];
        end
        return {v, n, r};
    endfunction

    logic [17:0] alu_res;
    assign alu_res = alu_calc(alu_op, alu_a, alu_b);
    assign alu_out = alu_res[15:0];
    assign alu_v   = alu_res[17];
    assign alu_n   = alu_res[16];
    assign alu_z   = (alu_res[15:0] == 16'h0);

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: one outstanding transaction tracked by its age in clock edges.
    bit          m_busy, m_owner, m_last, m_z, m_v, m_n, m_cv, m_cn;
    int          m_age, cyc, m_hs_cyc, m_done_cyc;
    logic [2:0]  m_op;
    logic [15:0] m_a, m_b, m_res, m_data;
    int          glog[$];
    bit          refill;
    bit          consumed0, consumed1;

    task automatic model_reset();
        m_busy = 0; m_last = 1; m_z = 0; m_v = 0; m_n = 0;
        m_op = 0; m_a = 0; m_b = 0; m_data = 0; m_age = 0;
    endtask

    task automatic new_req(input int port);
        logic [2:0]  op;
        logic [15:0] a, b;
        op = 3'($urandom % 8);
        a  = 16'($urandom);
        b  = ($urandom % 4 == 0) ? a : 16'($urandom);
        if (port == 0) begin req0_valid = 1; req0_op = op; req0_a = a; req0_b = b; end
        else           begin req1_valid = 1; req1_op = op; req1_a = a; req1_b = b; end
    endtask

    task automatic step();
        int          g;
        logic [17:0] c;
        #1;
        g = -1;
        if (!m_busy) begin
            if (req0_valid && req1_valid) begin
`ifdef ARB_FIXED_PRIO_EN
                g = 0;
`else
                g = m_last ? 0 : 1;
`endif
            end else if (req0_valid) g = 0;
            else if (req1_valid) g = 1;
        end
        check("req0_ready", req0_ready, (g == 0));
        check("req1_ready", req1_ready, (g == 1));
        check("busy", busy, m_busy);
        check("rsp0_valid", rsp0_valid, m_busy && m_age == 2 && !m_owner);
        check("rsp1_valid", rsp1_valid, m_busy && m_age == 2 && m_owner);
        check("rsp_data", rsp_data, m_data);
        check("flags", {flag_z, flag_v, flag_n}, {m_z, m_v, m_n});
        check("alu_opnds", {alu_op, alu_a, alu_b}, {m_op, m_a, m_b});
        consumed0 = 0;
        consumed1 = 0;
        if (rst) begin
            model_reset();
        end else if (m_busy) begin
            if (m_age == 1) begin
                m_data = m_res;
                m_z = (m_res == 16'h0);
                if (m_op < 3'd2) begin m_v = m_cv; m_n = m_cn; end
                m_age = 2;
            end else if (m_owner ? rsp1_ready : rsp0_ready) begin
                m_busy = 0;
                m_done_cyc = cyc;
            end
        end else if (g >= 0) begin
            m_busy = 1; m_age = 1; m_owner = g[0]; m_last = g[0];
            glog.push_back(g);
            m_hs_cyc = cyc;
            if (g == 0) begin m_op = req0_op; m_a = req0_a; m_b = req0_b; consumed0 = 1; end
            else        begin m_op = req1_op; m_a = req1_a; m_b = req1_b; consumed1 = 1; end
            c = alu_calc(m_op, m_a, m_b);
            m_res = c[15:0]; m_cv = c[17]; m_cn = c[16];
        end
        @(negedge clk);
        cyc++;
        if (consumed0) begin if (refill) new_req(0); else req0_valid = 0; end
        if (consumed1) begin if (refill) new_req(1); else req1_valid = 0; end
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (m_busy && k < budget);
        if (m_busy) check("drain_timeout", 1, 0);
    endtask

    task automatic reset_pulse();
        rst = 1;
        step();
        rst = 0;
    endtask

    task automatic issue0(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        req0_valid = 1; req0_op = op; req0_a = a; req0_b = b;
        drain(10);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1; refill = 0; cyc = 0;
        req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
        req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
        rsp0_ready = 1; rsp1_ready = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        model_reset();
        step();
        check("rst_data", rsp_data, 16'h0);

        // Single ADD on port 0, latency and flags.
        issue0(3'd0, 16'h0003, 16'h0004);
        check("add_data", rsp_data, 16'h0007);
        check("add_flags", {flag_z, flag_v, flag_n}, 3'b000);
        check("add_lat", m_done_cyc - m_hs_cyc, 2);

        // N set by ADD, then XOR writes Z only.
        issue0(3'd0, 16'h8000, 16'h0001);
        check("neg_data", rsp_data, 16'h8001);
        check("neg_flags", {flag_z, flag_v, flag_n}, 3'b001);
        issue0(3'd2, 16'h00FF, 16'h00FF);
        check("xor_data", rsp_data, 16'h0000);
        check("xor_flags", {flag_z, flag_v, flag_n}, 3'b101);

        // Reset while in EXEC drops the operation and clears flags.
        req0_valid = 1; req0_op = 3'd0; req0_a = 16'hFFFF; req0_b = 16'h0001;
        step();
        rst = 1;
        step();
        rst = 0;
        check("rst_exec_busy", busy, 0);
        check("rst_exec_flags", {flag_z, flag_v, flag_n}, 3'b000);
        check("rst_exec_rsp", {rsp0_valid, rsp1_valid}, 2'b00);
        step();
        check("rst_exec_norsp", {rsp0_valid, rsp1_valid}, 2'b00);
        new_req(0);
        new_req(1);
        glog.delete();
        drain(10);
        check("post_rst_gnt", glog[0], 0);
        drain(10);

        // Both ports continuously valid, responses acked immediately.
        reset_pulse();
        refill = 1;
        new_req(0);
        new_req(1);
        glog.delete();
        repeat (4) drain(10);
        check("rr_cnt", glog.size(), 4);
        for (int i = 0; i < 4 && i < glog.size(); i++) begin
`ifdef ARB_FIXED_PRIO_EN
            check("rr_order", glog[i], 0);
`else
            check("rr_order", glog[i], i % 2);
`endif
        end
        refill = 0;
        req0_valid = 0; req1_valid = 0;
        step();

        // Port 1 response stalled while port 0 waits.
        reset_pulse();
        new_req(1);
        rsp1_ready = 0;
        glog.delete();
        step();
        step();
        new_req(0);
        repeat (5) step();
        check("stall_v1", rsp1_valid, 1);
        check("stall_r0", req0_ready, 0);
        rsp1_ready = 1;
        step();
        step();
        check("stall_next_gnt", glog[glog.size() - 1], 0);
        drain(10);

        // Randomized traffic.
        for (int it = 0; it < 1500; it++) begin
            if (!req0_valid && $urandom % 3 == 0) new_req(0);
            else if (req0_valid && $urandom % 10 == 0) req0_valid = 0;
            if (!req1_valid && $urandom % 3 == 0) new_req(1);
            else if (req1_valid && $urandom % 10 == 0) req1_valid = 0;
            rsp0_ready = ($urandom % 2 == 0);
            rsp1_ready = ($urandom % 2 == 0);
            rst = ($urandom % 64 == 0);
            step();
        end
        rst = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares the single 16-bit ALU between two requesters, port 0 (pipeline EX stage) and port 1 (auxiliary address/branch unit). Uses round-robin arbitration with a valid/ready handshake on both request and response sides. The block registers operands, sequences one ALU operation at a time, captures the result, and owns the architectural Z/V/N flag register with per-opcode update rules. It sits between the requesters and the combinational ALU.

Parameters:
WIDTH, 16, operand/result width; must match the ALU datapath.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
req0_valid  in  1  port 0 request valid
req0_ready  out  1  port 0 request accepted this cycle
req0_op  in  3  port 0 ALU opcode
req0_a  in  WIDTH  port 0 operand A
req0_b  in  WIDTH  port 0 operand B
req1_valid, req1_ready, req1_op, req1_a, req1_b  same as port 0, for port 1
rsp0_valid  out  1  result valid for port 0
rsp0_ready  in  1  port 0 consumes result
rsp1_valid  out  1  result valid for port 1
rsp1_ready  in  1  port 1 consumes result
rsp_data  out  WIDTH  result (shared; qualified by rspN_valid)
alu_op  out  3  to ALU op
alu_a  out  WIDTH  to ALU a
alu_b  out  WIDTH  to ALU b
alu_out  in  WIDTH  from ALU out
alu_z, alu_v, alu_n  in  1 each  from ALU flags
flag_z, flag_v, flag_n  out  1 each  architectural flag register
busy  out  1  high whenever state != IDLE

Behaviour:
- One clock (clk); reset synchronous, active-high (rst). The reset value of every output and register is 0: state=IDLE, rsp*_valid=0, rsp_data=0, flags=0, alu_op/a/b=0. Last-grant pointer resets to 1, so port 0 wins the first contention.
- States: IDLE -> EXEC -> RESP -> IDLE.
- IDLE: grant = the only valid port; if both are valid, grant the port not granted last. reqN_ready = (state==IDLE) & grant==N, combinational from valid. At most one ready is high per cycle. On the handshake edge, latch op/a/b into operand registers, latch owner id, update last-grant, go to EXEC.
- Requesters hold valid and payload stable until ready. Dropping valid before ready is allowed; no grant occurs.
- alu_op/alu_a/alu_b are driven only from the operand registers, never combinationally from the request ports.
- EXEC (1 cycle): at the edge, capture alu_out into rsp_data and apply the flag update, then go to RESP.
- Flag update rule: op 000 (ADD) and 001 (SUB) write Z, V and N. All other ops (010 XOR, 011 RED, 111 PADDSB, 1xx shifts) write Z only; V and N hold their values.
- RESP: rspN_valid=1 for the owner only. rsp_data is stable while waiting. On rspN_ready=1, go to IDLE and drop valid on that edge.
- Latency: handshake at edge T, result captured at T+1, rspN_valid high from T+2 (the cycle after T+1). Minimum 3 cycles per operation; no new request is accepted until the response completes.
- A new request may be presented during RESP but is not accepted until IDLE.
- The ready of the non-owner port has no effect on the response.
- rst in any state overrides everything: the in-flight operation is dropped, no response is issued, flags are cleared, and the block returns to IDLE the next cycle.

Optional Feature:
ARB_FIXED_PRIO_EN — when defined, arbitration is fixed priority: port 0 always wins contention, and the last-grant pointer is unused and may be omitted. When undefined, round-robin as above.

Test Plan:
- Port 0 only, ADD a=0x0003 b=0x0004 -> req0_ready at T, rsp0_valid at T+2, rsp_data=0x0007, flags Z=0 V=0 N=0.
- ADD 0x8000+0x0001 -> rsp_data=0x8001, N=1. Then XOR 0x00FF^0x00FF -> rsp_data=0x0000, Z=1, N stays 1, V stays 0.
- Both ports valid continuously from reset, responses acked immediately -> grant order 0,1,0,1; each port served once per 2 operations.
- rsp1_ready held 0 for 5 cycles -> rsp1_valid and rsp_data stay stable and req0_ready stays 0; on ack, the block returns to IDLE and port 0 is granted next.
- rst asserted in EXEC -> next cycle state IDLE, no rsp*_valid pulse, flags=0; the first request after reset goes to port 0.
- With ARB_FIXED_PRIO_EN and both ports always valid -> port 0 granted every operation, port 1 never granted.
